// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side executor.
// Holds the instruction encoding, the signed result type and the executor FSM state.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_OUTPUT = 2'd3
  } exec_state_t;

endpackage

// File: rtl/instr_exec_reader_if.sv
// Bus between instr_exec_reader (master) and its environment (slave).
// res_* follow valid/ready: a transfer happens on a rising edge with res_valid && res_ready;
// once res_valid is high the master holds every res_* stable until that transfer.
interface instr_exec_reader_if
  import instr_register_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int COUNT_W = 6
);

  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic [COUNT_W-1:0] count;
  logic [ADDR_W-1:0]  read_pointer;
  instruction_t       instruction_word;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  result_t            res_data;
  opcode_t            res_opc;
  logic [ADDR_W-1:0]  res_addr;
  logic               res_err;
  logic               done;
  exec_state_t        state;

  modport master (
    input  start, start_addr, count, instruction_word, res_ready,
    output read_pointer, busy, res_valid, res_data, res_opc, res_addr, res_err, done, state
  );

  modport slave (
    output start, start_addr, count, instruction_word, res_ready,
    input  read_pointer, busy, res_valid, res_data, res_opc, res_addr, res_err, done, state
  );

endinterface

// File: rtl/instr_exec_reader_alu.sv
// Combinational executor for one instruction_t: signed 32-bit operands, signed 64-bit result.
// Divide/modulo by zero yields 0 and raises div_zero instead of producing X.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc_i,
  input  operand_t op_a_i,
  input  operand_t op_b_i,
  output result_t  result_o,
  output logic     div_zero_o
);

  result_t a_ext;
  result_t b_ext;
  logic    b_is_zero;

  // Widening first keeps ADD/SUB/MULT exact and makes INT_MIN / -1 representable.
  assign a_ext     = result_t'(op_a_i);
  assign b_ext     = result_t'(op_b_i);
  assign b_is_zero = (op_b_i == '0);

  always_comb begin
    result_o   = '0;
    div_zero_o = 1'b0;
    case (opc_i)
      ZERO:  result_o = '0;
      PASSA: result_o = a_ext;
      PASSB: result_o = b_ext;
      ADD:   result_o = a_ext + b_ext;
      SUB:   result_o = a_ext - b_ext;
      MULT:  result_o = a_ext * b_ext;
      DIV: begin
        div_zero_o = b_is_zero;
        if (!b_is_zero) result_o = a_ext / b_ext;
      end
      MOD: begin
        div_zero_o = b_is_zero;
        if (!b_is_zero) result_o = a_ext % b_ext;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks count locations of the instruction register from start_addr, executes each one and
// streams the results over valid/ready. Define INSTR_EXEC_DIVZERO_FLAG_EN to drive res_err.
module instr_exec_reader
  import instr_register_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int COUNT_W = 6
)(
  input  logic                clk,
  input  logic                reset,
  instr_exec_reader_if.master bus
);

`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  localparam logic DIVZERO_FLAG_EN = 1'b1;
`else
  localparam logic DIVZERO_FLAG_EN = 1'b0;
`endif

  exec_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  instruction_t       ir_q, ir_d;
  logic               valid_q, valid_d;
  result_t            data_q, data_d;
  opcode_t            opc_q, opc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  result_t            alu_result;
  logic               alu_div_zero;

  instr_alu u_alu (
    .opc_i      (ir_q.opc),
    .op_a_i     (ir_q.op_a),
    .op_b_i     (ir_q.op_b),
    .result_o   (alu_result),
    .div_zero_o (alu_div_zero)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    data_d  = data_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            ptr_d   = bus.start_addr;
            rem_d   = bus.count;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        ir_d    = bus.instruction_word;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        data_d  = alu_result;
        opc_d   = ir_q.opc;
        addr_d  = ptr_q;
        err_d   = alu_div_zero & DIVZERO_FLAG_EN;
        valid_d = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - 1'b1;
          if (rem_q == COUNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Pointer width gives the 31 -> 0 wrap for free.
            ptr_d   = ptr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      opc_q   <= ZERO;
      addr_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.read_pointer = ptr_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.res_valid    = valid_q;
  assign bus.res_data     = data_q;
  assign bus.res_opc      = opc_q;
  assign bus.res_addr     = addr_q;
  assign bus.res_err      = valid_q & err_q;
  assign bus.done         = done_q;
  assign bus.state        = state_q;

endmodule
